// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its dump reader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDumpReq,
    StDumpWait,
    StDumpSend
  } loader_state_t;

  localparam int unsigned ErrOverflowBit = 0;
  localparam int unsigned ErrTimeoutBit  = 1;
  localparam int unsigned WORD_BYTES     = 4;

endpackage

// File: rtl/dump_reader.sv
// Walks a window of data BRAM and streams it to the host, one word per request/wait/send cycle.
module dump_reader
  import loader_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] DUMP_BASE  = '0,
  parameter int unsigned      DUMP_WORDS = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dm_rdata_i,
  input  logic             m_ready_i,
  output logic             m_valid_o,
  output logic             m_last_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic [WIDTH-1:0] dm_addr_o,
  output logic             finish_o
);

  localparam int unsigned IdxW = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;

  loader_state_t   phase;
  logic [IdxW-1:0] idx;
  logic            mValidQ;
  logic            mLastQ;
  logic [WIDTH-1:0] mDataQ;
  logic            isLast;

  assign isLast    = (idx == IdxW'(DUMP_WORDS - 1));
  assign dm_addr_o = DUMP_BASE + WIDTH'(idx) * WIDTH'(WORD_BYTES);
  assign finish_o  = mValidQ && m_ready_i && mLastQ;
  assign m_valid_o = mValidQ;
  assign m_last_o  = mLastQ;
  assign m_data_o  = mDataQ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase   <= StIdle;
      idx     <= '0;
      mValidQ <= 1'b0;
      mLastQ  <= 1'b0;
      mDataQ  <= '0;
    end else begin
      unique case (phase)
        StIdle: begin
          if (start_i) begin
            phase <= StDumpReq;
            idx   <= '0;
          end
        end
        StDumpReq: phase <= StDumpWait;
        StDumpWait: begin
          // Address was presented last cycle, so read data is valid now.
          mDataQ  <= dm_rdata_i;
          mValidQ <= 1'b1;
          mLastQ  <= isLast;
          phase   <= StDumpSend;
        end
        StDumpSend: begin
          if (m_ready_i) begin
            mValidQ <= 1'b0;
            mLastQ  <= 1'b0;
            if (isLast) begin
              phase <= StIdle;
            end else begin
              idx   <= idx + 1'b1;
              phase <= StDumpReq;
            end
          end
        end
        default: phase <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Host-side loader: streams a program into instruction BRAM, runs the core, dumps data BRAM.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      IM_DEPTH   = 1024,
  parameter logic [WIDTH-1:0] DUMP_BASE  = '0,
  parameter int unsigned      DUMP_WORDS = 16,
  parameter int unsigned      MAX_CYCLES = 32'd1 << 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [WIDTH-1:0] m_data,
  output logic             cpu_rst,
  input  logic [WIDTH-1:0] cpu_im_addr,
  input  logic             cpu_dm_we,
  input  logic [WIDTH-1:0] cpu_dm_addr,
  input  logic [WIDTH-1:0] cpu_dm_wdata,
  input  logic             cpu_done,
  output logic             im_we,
  output logic [WIDTH-1:0] im_addr,
  output logic [WIDTH-1:0] im_wdata,
  output logic             dm_we,
  output logic [WIDTH-1:0] dm_addr,
  output logic [WIDTH-1:0] dm_wdata,
  input  logic [WIDTH-1:0] dm_rdata,
  output logic             busy,
  output logic             err_overflow,
  output logic             err_timeout
);

  localparam int unsigned CntW = $clog2(IM_DEPTH + 1);
  localparam int unsigned RunW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  loader_state_t    state;
  logic [CntW-1:0]  wordCnt;
  logic [RunW-1:0]  runCnt;
  logic             sReadyQ;
  logic             cpuRstQ;
  logic             imWeQ;
  logic [WIDTH-1:0] imAddrQ;
  logic [WIDTH-1:0] imWdataQ;
  logic [1:0]       errQ;

  logic             sHs;
  logic             coreActive;
  logic             loadFull;
  logic             runTimeout;
  logic             runExit;
  logic             dumpStart;
  logic             dumpFinish;
  logic [WIDTH-1:0] dumpAddr;

  assign sHs        = s_valid && sReadyQ;
  // First RUN cycle still holds the core in reset while the final program word lands.
  assign coreActive = (state == StRun) && !cpuRstQ;
  assign loadFull   = (wordCnt >= CntW'(IM_DEPTH));
  assign runTimeout = (runCnt == RunW'(MAX_CYCLES - 1));
  assign runExit    = coreActive && (cpu_done || runTimeout);
  assign dumpStart  = runExit ||
                      ((state == StLoad) && sHs && s_last && (errQ[ErrOverflowBit] || loadFull));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      wordCnt  <= '0;
      runCnt   <= '0;
      sReadyQ  <= 1'b0;
      cpuRstQ  <= 1'b1;
      imWeQ    <= 1'b0;
      imAddrQ  <= '0;
      imWdataQ <= '0;
      errQ     <= '0;
    end else begin
      imWeQ <= 1'b0;
      unique case (state)
        StIdle: begin
          sReadyQ <= 1'b1;
          cpuRstQ <= 1'b1;
          if (sHs) begin
            errQ     <= '0;
            imWeQ    <= 1'b1;
            imAddrQ  <= '0;
            imWdataQ <= s_data;
            wordCnt  <= CntW'(1);
            if (s_last) begin
              state   <= StRun;
              sReadyQ <= 1'b0;
            end else begin
              state <= StLoad;
            end
          end
        end
        StLoad: begin
          if (sHs) begin
            if (loadFull) begin
              errQ[ErrOverflowBit] <= 1'b1;
            end else begin
              imWeQ    <= 1'b1;
              imAddrQ  <= WIDTH'(wordCnt) * WIDTH'(WORD_BYTES);
              imWdataQ <= s_data;
              wordCnt  <= wordCnt + 1'b1;
            end
            if (s_last) begin
              sReadyQ <= 1'b0;
              state   <= dumpStart ? StDumpReq : StRun;
            end
          end
        end
        StRun: begin
          sReadyQ <= 1'b0;
          if (runExit) begin
            state   <= StDumpReq;
            cpuRstQ <= 1'b1;
            if (!cpu_done) errQ[ErrTimeoutBit] <= 1'b1;
          end else begin
            cpuRstQ <= 1'b0;
            runCnt  <= coreActive ? runCnt + 1'b1 : '0;
          end
        end
        // The top parks in StDumpReq while dump_reader steps through its own phases.
        StDumpReq, StDumpWait, StDumpSend: begin
          if (dumpFinish) begin
            state   <= StIdle;
            sReadyQ <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  dump_reader #(
    .WIDTH     (WIDTH),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_WORDS(DUMP_WORDS)
  ) u_dump_reader (
    .clk_i     (clk),
    .rst_ni    (rst),
    .start_i   (dumpStart),
    .dm_rdata_i(dm_rdata),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_last_o  (m_last),
    .m_data_o  (m_data),
    .dm_addr_o (dumpAddr),
    .finish_o  (dumpFinish)
  );

  assign s_ready      = sReadyQ;
  assign cpu_rst      = cpuRstQ;
  assign busy         = (state != StIdle);
  assign err_overflow = errQ[ErrOverflowBit];
  assign err_timeout  = errQ[ErrTimeoutBit];

  assign im_we    = imWeQ;
  assign im_addr  = coreActive ? cpu_im_addr : imAddrQ;
  assign im_wdata = imWdataQ;
  assign dm_we    = coreActive && cpu_dm_we;
  assign dm_addr  = coreActive ? cpu_dm_addr : ((state == StDumpReq) ? dumpAddr : '0);
  assign dm_wdata = coreActive ? cpu_dm_wdata : '0;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with behavioural BRAMs and a reference data-memory model.
module tb_program_loader;

  localparam int unsigned IMD   = 8;
  localparam logic [31:0] DBASE = 32'h0000_0100;
  localparam int unsigned DW    = 4;
  localparam int unsigned MAXC  = 100;
  localparam int unsigned WBASE = 32'h100 / 4;

  typedef struct packed {
    logic [31:0] imA;
    logic        we;
    logic [31:0] dA;
    logic [31:0] dD;
    logic        expWe;
    logic [31:0] expDA;
    logic [31:0] expDD;
    logic [31:0] expImA;
  } pt_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid, m_last, m_ready = 1'b0;
  logic [31:0] m_data;
  logic        cpu_rst, cpu_dm_we = 1'b0, cpu_done = 1'b0;
  logic [31:0] cpu_im_addr = '0, cpu_dm_addr = '0, cpu_dm_wdata = '0;
  logic        im_we, dm_we;
  logic [31:0] im_addr, im_wdata, dm_addr, dm_wdata, dm_rdata;
  logic        busy, err_overflow, err_timeout;

  int checks = 0;
  int errors = 0;
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] refMem [256];
  logic [31:0] progWords [16];
  int  imWeCount;
  bit  cpuRstLowSeen;
  pt_vec_t vecs [4];

  always #5 clk = ~clk;

  // Behavioural BRAMs (1-cycle read latency) and port monitors.
  always @(posedge clk) begin
    if (im_we) begin
      imem[im_addr[9:2]] <= im_wdata;
      imWeCount <= imWeCount + 1;
    end
    if (dm_we) dmem[dm_addr[9:2]] <= dm_wdata;
    dm_rdata <= dmem[dm_addr[9:2]];
    if (!cpu_rst) cpuRstLowSeen <= 1'b1;
  end

  program_loader #(
    .WIDTH     (32),
    .IM_DEPTH  (IMD),
    .DUMP_BASE (DBASE),
    .DUMP_WORDS(DW),
    .MAX_CYCLES(MAXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .m_data      (m_data),
    .cpu_rst     (cpu_rst),
    .cpu_im_addr (cpu_im_addr),
    .cpu_dm_we   (cpu_dm_we),
    .cpu_dm_addr (cpu_dm_addr),
    .cpu_dm_wdata(cpu_dm_wdata),
    .cpu_done    (cpu_done),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .busy        (busy),
    .err_overflow(err_overflow),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_dm_we"}, dm_we, 0);
    chk({tag, "_dm_addr"}, dm_addr, 0);
    chk({tag, "_dm_wdata"}, dm_wdata, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_ovf"}, err_overflow, 0);
    chk({tag, "_err_to"}, err_timeout, 0);
  endtask

  task automatic loadProg(input int n);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = progWords[k];
      s_last  = (k == n - 1);
      for (int b = 0; b < 50 && !s_ready; b++) step();
      chk("load_ready", s_ready, 1);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Acts as the core: random data writes each active cycle, done at active cycle doneAt.
  task automatic runCore(input int doneAt, output int active);
    int unsigned wi;
    active = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      cpu_done  = 1'b0;
      cpu_dm_we = 1'b0;
      if (!cpu_rst) begin
        if (active == doneAt) cpu_done = 1'b1;
        active++;
        cpu_im_addr = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          wi = ($urandom_range(0, 1) == 1) ? WBASE + $urandom_range(0, DW - 1)
                                           : $urandom_range(0, 255);
          cpu_dm_we    = 1'b1;
          cpu_dm_addr  = wi * 4;
          cpu_dm_wdata = $urandom;
          refMem[wi]   = cpu_dm_wdata;
        end
      end else if (active > 0) begin
        break;
      end
    end
    cpu_dm_we = 1'b0;
    cpu_done  = 1'b0;
  endtask

  // Consumes one dump; cpu requests are driven throughout and must not reach data BRAM.
  task automatic collectDump(input bit bp);
    int got = 0;
    bit held = 1'b0;
    logic [31:0] heldData = '0;
    for (int c = 0; c < 200 && got < DW; c++) begin
      m_ready      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cpu_dm_we    = 1'b1;
      cpu_dm_addr  = DBASE + 4 * $urandom_range(0, DW - 1);
      cpu_dm_wdata = $urandom;
      #1;
      chk("dump_no_dm_we", dm_we, 0);
      if (held) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, heldData);
      end
      held = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          chk("dump_data", m_data, refMem[WBASE + got]);
          chk("dump_last", m_last, (got == DW - 1));
          got++;
        end else begin
          held     = 1'b1;
          heldData = m_data;
        end
      end
      @(posedge clk);
      #1;
    end
    m_ready   = 1'b0;
    cpu_dm_we = 1'b0;
    chk("dump_count", got, DW);
    chk("after_dump_busy", busy, 0);
    chk("after_dump_ready", s_ready, 1);
  endtask

  task automatic randomRun();
    int n;
    int doneAt;
    int act;
    n = $urandom_range(1, IMD);
    for (int k = 0; k < n; k++) progWords[k] = $urandom;
    loadProg(n);
    doneAt = $urandom_range(0, 30);
    runCore(doneAt, act);
    chk("rnd_active", act, doneAt + 1);
    chk("rnd_err_to", err_timeout, 0);
    chk("rnd_err_ovf", err_overflow, 0);
    chk("rnd_first_dm_addr", dm_addr, DBASE);
    collectDump(1'b1);
    for (int k = 0; k < n; k++) chk("rnd_imem", imem[k], progWords[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int act;
    logic [31:0] hd, ha;
    for (int i = 0; i < 256; i++) begin
      dmem[i]   = '0;
      refMem[i] = '0;
      imem[i]   = '0;
    end
    imWeCount     = 0;
    cpuRstLowSeen = 1'b0;

    vecs[0] = '{32'h0, 1'b1, 32'h40, 32'hDEAD, 1'b1, 32'h40, 32'hDEAD, 32'h0};
    vecs[1] = '{32'h4, 1'b0, 32'h44, 32'h1234, 1'b0, 32'h44, 32'h1234, 32'h4};
    vecs[2] = '{32'h8, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_A5A5, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_A5A5, 32'h8};
    vecs[3] = '{32'hC, 1'b1, 32'h104, 32'hCAFE_F00D, 1'b1, 32'h104, 32'hCAFE_F00D, 32'hC};

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("por");
    rst = 1'b1;
    chk("ready_before_edge", s_ready, 0);
    step();
    chk("ready_after_release", s_ready, 1);

    // Three-word load, then pass-through and dump.
    progWords[0] = 32'h11;
    progWords[1] = 32'h22;
    progWords[2] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = progWords[k];
      s_last  = (k == 2);
      step();
      chk("load_im_we", im_we, 1);
      chk("load_im_addr", im_addr, 32'(4 * k));
      chk("load_im_wdata", im_wdata, progWords[k]);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("cpu_rst_during_last_pulse", cpu_rst, 1);
    step();
    chk("cpu_rst_falls", cpu_rst, 0);
    chk("im_we_after_load", im_we, 0);
    for (int k = 0; k < 3; k++) chk("imem_word", imem[k], progWords[k]);

    for (int v = 0; v < 4; v++) begin
      cpu_im_addr  = vecs[v].imA;
      cpu_dm_we    = vecs[v].we;
      cpu_dm_addr  = vecs[v].dA;
      cpu_dm_wdata = vecs[v].dD;
      if (vecs[v].we) refMem[vecs[v].dA[9:2]] = vecs[v].dD;
      #1;
      chk("pt_dm_we", dm_we, vecs[v].expWe);
      chk("pt_dm_addr", dm_addr, vecs[v].expDA);
      chk("pt_dm_wdata", dm_wdata, vecs[v].expDD);
      chk("pt_im_addr", im_addr, vecs[v].expImA);
      chk("pt_im_we", im_we, 0);
      step();
    end
    for (int i = 0; i < DW; i++) begin
      cpu_dm_we    = 1'($urandom_range(0, 1));
      cpu_dm_addr  = DBASE + 4 * i;
      cpu_dm_wdata = $urandom;
      if (cpu_dm_we) refMem[WBASE + i] = cpu_dm_wdata;
      step();
    end
    cpu_dm_we = 1'b0;
    cpu_done  = 1'b1;
    step();
    cpu_done = 1'b0;
    chk("done_cpu_rst", cpu_rst, 1);
    chk("done_dm_addr", dm_addr, DBASE);
    chk("done_dm_we", dm_we, 0);
    chk("done_t1_valid", m_valid, 0);
    step();
    chk("done_t2_valid", m_valid, 0);
    step();
    chk("done_t3_valid", m_valid, 1);
    chk("dmem_passthrough_write", dmem[32'h40 >> 2], 32'hDEAD);
    collectDump(1'b0);

    // Overflow: IM_DEPTH+2 words; RUN skipped; dump held 5 cycles.
    for (int k = 0; k < IMD + 2; k++) progWords[k] = $urandom;
    imWeCount     = 0;
    cpuRstLowSeen = 1'b0;
    loadProg(IMD + 2);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_cpu_rst", cpu_rst, 1);
    for (int b = 0; b < 20 && !m_valid; b++) step();
    chk("ovf_dump_valid", m_valid, 1);
    hd = m_data;
    ha = dm_addr;
    chk("ovf_dump_first", hd, refMem[WBASE]);
    for (int h = 0; h < 5; h++) begin
      step();
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, hd);
      chk("stall_dm_addr", dm_addr, ha);
    end
    collectDump(1'b0);
    chk("ovf_im_we_count", imWeCount, IMD);
    chk("ovf_run_skipped", cpuRstLowSeen, 0);
    chk("ovf_sticky", err_overflow, 1);
    for (int k = 0; k < IMD; k++) chk("ovf_imem", imem[k], progWords[k]);

    // Timeout: the next load clears the overflow flag, core never signals done.
    progWords[0] = $urandom;
    loadProg(1);
    chk("ovf_cleared", err_overflow, 0);
    runCore(-1, act);
    chk("to_active_cycles", act, MAXC);
    chk("to_flag", err_timeout, 1);
    chk("to_dm_addr", dm_addr, DBASE);
    collectDump(1'b1);

    // Done on the final allowed cycle wins over timeout.
    progWords[0] = $urandom;
    loadProg(1);
    chk("to_cleared", err_timeout, 0);
    runCore(MAXC - 1, act);
    chk("tie_active_cycles", act, MAXC);
    chk("tie_no_timeout", err_timeout, 0);
    collectDump(1'b1);

    for (int r = 0; r < 3; r++) randomRun();

    // Reset in the middle of LOAD.
    s_valid = 1'b1;
    s_data  = 32'hAAAA_0001;
    s_last  = 1'b0;
    step();
    s_data = 32'hAAAA_0002;
    step();
    rst = 1'b0;
    #1;
    checkResetOutputs("rst_load");
    s_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    randomRun();

    // Reset in the middle of DUMP_SEND.
    progWords[0] = $urandom;
    loadProg(1);
    runCore(2, act);
    m_ready = 1'b0;
    for (int b = 0; b < 20 && !m_valid; b++) step();
    chk("pre_rst_valid", m_valid, 1);
    rst = 1'b0;
    #1;
    checkResetOutputs("rst_dump");
    step();
    rst = 1'b1;
    step();
    randomRun();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
